// File: rtl/hardmatch_pkg.sv
// hardmatch_pkg: shared result-word type and round-robin pointer helper for the match result arbiter.
package hardmatch_pkg;
  localparam int MATCH_W = 10;
  typedef logic [MATCH_W-1:0] match_word_t;
  function automatic int next_rr_ptr(input int cur, input int n);
    return (cur + 1) % n;
  endfunction
endpackage

// File: rtl/hm_rr_arbiter.sv
// hm_rr_arbiter: combinational round-robin grant, first requester strictly after last.
module hm_rr_arbiter
  import hardmatch_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    // Scan lowest priority first so the nearest requester after last wins.
    for (int k = N; k >= 1; k--) begin
      if (en && req[next_rr_ptr(int'(last) + k - 1, N)]) begin
        gnt = N'(1) << next_rr_ptr(int'(last) + k - 1, N);
        gnt_idx = IW'(next_rr_ptr(int'(last) + k - 1, N));
      end
    end
  end
endmodule

// File: rtl/hardmatch_result_arbiter.sv
// hardmatch_result_arbiter: round-robin merge of show-ahead match FIFOs into one
// registered, channel-tagged result stream with saturating per-channel pop counters.
module hardmatch_result_arbiter
  import hardmatch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  localparam int CHW = $clog2(NUM_CH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH*MATCH_W-1:0] in_data,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ack,
  output logic [MATCH_W-1:0]        out_data,
  output logic [CHW-1:0]            out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*CNT_W-1:0]   match_count
);
  logic load;
  logic [NUM_CH-1:0] gnt;
  logic [CHW-1:0] gnt_idx, last_q, last_d, out_chan_q, out_chan_d;
  logic out_valid_q, out_valid_d;
  match_word_t out_data_q, out_data_d;
  match_word_t in_word [NUM_CH];
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_word
    assign in_word[c] = in_data[c*MATCH_W +: MATCH_W];
  end
  assign load = !out_valid_q || out_ready;
  hm_rr_arbiter #(.N(NUM_CH)) u_arb (
    .req    (in_valid),
    .last   (last_q),
    .en     (load && !reset),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );
  always_comb begin
    out_valid_d = load ? |gnt : out_valid_q;
    out_data_d = |gnt ? in_word[gnt_idx] : out_data_q;
    out_chan_d = |gnt ? gnt_idx : out_chan_q;
    last_d = |gnt ? gnt_idx : last_q;
    cnt_d = cnt_q;
    for (int c = 0; c < NUM_CH; c++)
      if (gnt[c] && cnt_q[c] != '1) cnt_d[c] = cnt_q[c] + CNT_W'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      last_q <= CHW'(NUM_CH - 1);
      cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ack = gnt;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign match_count = cnt_q;
endmodule

// File: tb/tb_hardmatch_result_arbiter.sv
// tb_hardmatch_result_arbiter: directed and random checks against a reference model and result scoreboard.
module tb_hardmatch_result_arbiter;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N*10-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_ack;
  logic [9:0] out_data;
  logic [1:0] out_chan;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [N*16-1:0] match_count;
  int checks = 0;
  int failures = 0;
  logic [9:0] src [N][$];
  logic [11:0] sb [$];
  logic mv = 1'b0;
  int mlast = N - 1;
  logic [15:0] mcnt [N];
  int waitc [N];
  int maxwait = 0;
  logic [N-1:0] last_ack;

  hardmatch_result_arbiter #(.NUM_CH(N), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .match_count(match_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mcnt_vec();
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = mcnt[i];
    return v;
  endfunction

  task automatic cyc(input logic rdy);
    int g;
    logic [N-1:0] eg;
    logic [11:0] e;
    @(negedge clock);
    out_ready = rdy;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = src[i].size() != 0;
      in_data[i*10 +: 10] = in_valid[i] ? src[i][0] : 10'($urandom);
    end
    #1;
    g = -1;
    if (!reset && (!mv || rdy))
      for (int k = N; k >= 1; k--) if (in_valid[(mlast + k) % N]) g = (mlast + k) % N;
    eg = (g >= 0) ? N'(1) << g : '0;
    last_ack = in_ack;
    chk("ack", in_ack, eg);
    chk("out_valid", out_valid, mv);
    chk("count", match_count, mcnt_vec());
    if (mv && sb.size() != 0) begin
      e = sb[0];
      chk("out_data", out_data, e[9:0]);
      chk("out_chan", out_chan, e[11:10]);
      if (rdy && !reset) void'(sb.pop_front());
    end
    if (reset) begin
      sb.delete();
      mv = 1'b0;
      mlast = N - 1;
      for (int i = 0; i < N; i++) begin
        mcnt[i] = '0;
        waitc[i] = 0;
      end
    end else begin
      if (g >= 0) begin
        sb.push_back({2'(g), src[g].pop_front()});
        if (mcnt[g] != 16'hFFFF) mcnt[g]++;
        mlast = g;
        for (int i = 0; i < N; i++) begin
          waitc[i] = (i != g && in_valid[i]) ? waitc[i] + 1 : 0;
          if (waitc[i] > maxwait) maxwait = waitc[i];
        end
      end
      if (!mv || rdy) mv = (g >= 0);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mcnt[i] = '0;
      waitc[i] = 0;
    end
    reset = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 10'h0);
    chk("rst_chan", out_chan, 2'd0);
    chk("rst_count", match_count, 64'h0);
    reset = 1'b0;
    // single channel, same-cycle ack, 1-cycle latency
    src[2].push_back(10'h2C5);
    cyc(1'b1);
    chk("first_ack", last_ack, 4'b0100);
    chk("first_valid", out_valid, 1'b1);
    chk("first_data", out_data, 10'h2C5);
    chk("first_chan", out_chan, 2'd2);
    chk("first_count", match_count[47:32], 16'd1);
    cyc(1'b1);
    reset = 1'b1;
    cyc(1'b1);
    reset = 1'b0;
    // all channels valid: strict rotation from channel 0
    for (int i = 0; i < N; i++) for (int j = 0; j < 3; j++) src[i].push_back(10'(i * 16 + j));
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1);
      chk("rr_ack", last_ack, N'(1) << (k % N));
    end
    cyc(1'b1);
    for (int i = 0; i < N; i++) chk("rr_count", match_count[i*16 +: 16], 16'd3);
    // stall holds word and suppresses ack
    src[1].push_back(10'h101);
    src[1].push_back(10'h1FF);
    cyc(1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0);
      chk("stall_ack", last_ack, 4'b0000);
      chk("stall_data", out_data, 10'h101);
    end
    cyc(1'b1);
    chk("unstall_ack", last_ack, 4'b0010);
    chk("unstall_data", out_data, 10'h1FF);
    cyc(1'b1);
    // counter saturation
    reset = 1'b1;
    cyc(1'b1);
    reset = 1'b0;
    @(negedge clock);
    force dut.cnt_q = 64'hFFFE_0000_0000_0000;
    mcnt[3] = 16'hFFFE;
    @(posedge clock);
    @(negedge clock);
    release dut.cnt_q;
    for (int k = 0; k < 3; k++) src[3].push_back(10'(k + 5));
    for (int k = 0; k < 4; k++) cyc(1'b1);
    chk("sat_count", match_count[63:48], 16'hFFFF);
    // reset while holding a result
    src[2].push_back(10'h0AA);
    cyc(1'b1);
    chk("pre_rst_data", out_data, 10'h0AA);
    src[0].push_back(10'h011);
    src[3].push_back(10'h033);
    reset = 1'b1;
    cyc(1'b0);
    chk("rst_ack", last_ack, 4'b0000);
    reset = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_count", match_count, 64'h0);
    cyc(1'b1);
    chk("post_rst_gnt", last_ack, 4'b0001);
    cyc(1'b1);
    cyc(1'b1);
    // random traffic
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++)
        if (src[i].size() < 4 && $urandom_range(0, 2) != 0) src[i].push_back(10'($urandom));
      cyc(1'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0 && src[0].size() == 0 && src[1].size() == 0 &&
          src[2].size() == 0 && src[3].size() == 0) break;
      cyc(1'b1);
    end
    chk("drain_sb", 64'(sb.size()), 64'd0);
    chk("drain_src", 64'(src[0].size() + src[1].size() + src[2].size() + src[3].size()), 64'd0);
    chk("starvation", 64'(maxwait > N - 1), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
